item_display_sequencer: RTL and testbench
=========================================

// Module: item_display_sequencer
// PURPOSE
//  Sequences the 3-bit item code that feeds the six-digit HEX item-name decoder (code order 000,001,010,100,101,111).
//  - Manual mode: passes the switch-selected code through.
//  - Auto mode: steps through the six valid items on a dwell timer or on a step button.
//  - Pick event: locks the shown item and flashes it for a fixed time.
//  - Sits between board SW/KEY inputs and the item-name decoder in the top level.
// PARAMETERS
//  CLK_DIV      25_000_000  clk cycles per internal tick (0.5 s at 50 MHz); must be >= 2
//  DWELL_TICKS  4           ticks an item is shown in auto mode before advancing; >= 1
//  FLASH_TICKS  6           ticks spent in FLASH after an accepted pick; >= 1
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  synchronous, active-low reset
//  mode_auto   in   1  level; 1 = auto scroll, 0 = manual
//  sel_code    in   3  manual item select (switches)
//  step        in   1  active-high level (debounced KEY); rising edge advances in auto mode
//  pick        in   1  active-high level; rising edge requests pick of the shown item
//  item_code   out  3  code to the decoder; ITEM_BLANK (3'b011) blanks all digits
//  item_valid  out  1  item_code is one of the six valid items
//  flashing    out  1  high while in FLASH
//  pick_count  out  8  saturating count of accepted picks
// BEHAVIOUR
//  - Reset: item_code=ITEM_BLANK, item_valid=0, flashing=0, pick_count=0, state IDLE.
//    All counters and edge-detect registers clear. Reset mid-FLASH aborts the flash immediately.
//  - Tick: free-running prescaler 0..CLK_DIV-1; tick is a 1-cycle pulse on wrap.
//  - step/pick: rising-edge detected internally (1 register stage); a held level produces one event.
//  - States: IDLE, MANUAL, AUTO, FLASH. All outputs are registered.
//  - IDLE: after reset_n deasserts, goes next cycle to AUTO if mode_auto, else MANUAL.
//  - MANUAL: item_code <= sel_code, 1-cycle latency.
//    item_valid = (sel_code in valid set); codes 011 and 110 output as-is with item_valid=0.
//  - AUTO:
//    - Entry: shows the current item_code if valid, else ITEM_SHOES (000); dwell counter cleared.
//    - Advance order: 000->001->010->100->101->111->000 (wrap).
//    - Advance when dwell reaches DWELL_TICKS, or on a step edge (immediate); either clears dwell.
//    - step edge and dwell expiry in the same cycle: advance exactly once.
//  - Mode change: a mode_auto toggle moves MANUAL<->AUTO next cycle and clears dwell.
//  - Pick: a pick edge with item_valid=1 enters FLASH.
//    - The current code is latched as locked_code; pick_count increments, saturating at 255.
//    - A pick edge with item_valid=0 is ignored.
//    - pick and step edges in the same cycle: pick wins, no advance.
//  - FLASH:
//    - flashing=1; runs for FLASH_TICKS ticks, then returns to AUTO/MANUAL per the current mode_auto.
//    - AUTO re-entry resumes at locked_code with dwell cleared.
//    - step, pick and mode changes are ignored in FLASH.
//    - item_valid=1 throughout.
// CONFIGURATION
//  ITEM_SEQ_BLINK_EN
//  - Defined: during FLASH, item_code alternates locked_code / ITEM_BLANK on each tick, starting with ITEM_BLANK on the first tick.
//  - Undefined: item_code holds locked_code steadily for the whole FLASH.
//  - State timing, flashing and item_valid are identical in both builds.
// STRUCTURE
//  item_seq_pkg:
//  - typedef logic [2:0] item_code_t.
//  - Constants ITEM_SHOES=000, ITEM_JEWELRY=001, ITEM_ORNAMENT=010, ITEM_SUIT=100, ITEM_COAT=101, ITEM_SOCKS=111, ITEM_BLANK=011.
//  - enum seq_state_t {IDLE, MANUAL, AUTO, FLASH}.
//  - Functions is_valid_item() and next_item().
//  Sub-module tick_prescaler (CLK_DIV) produces the tick pulse; FSM, dwell/flash counters and edge detect stay in this module.
// TESTING (CLK_DIV=4, DWELL_TICKS=2, FLASH_TICKS=4)
//  1. Reset: hold reset_n=0 5 clk with mode_auto=1 -> item_code=011, item_valid=0, pick_count=0.
//     Release -> AUTO at 000.
//  2. Auto scroll: no input 8 ticks -> 000,001,010,100,101 (2 ticks each).
//     Continue -> 111 then wrap to 000.
//  3. Step: AUTO on 001, step edge one clk before dwell expiry -> single advance to 010, dwell restarts.
//     Holding step high 20 clk advances only once.
//  4. Manual: mode_auto=0, sel_code=110 -> item_code=110, item_valid=0.
//     pick ignored, pick_count unchanged.
//     sel_code=101 -> item_code=101 next clk.
//  5. Pick and flash: AUTO on 100, pick and step edges in the same clk -> FLASH, pick_count=1, no advance.
//     With BLINK_EN: item_code 011,100,011,100 per tick. Without: 100 steady.
//     After 4 ticks: flashing=0, AUTO resumes at 100.
//  6. Saturation/reset: 256 accepted picks -> pick_count=255.
//     reset_n=0 mid-FLASH -> flashing=0, item_code=011 on the next clk.

Source files
------------

// File: rtl/item_seq_pkg.sv
// Item codes, FSM states and item helpers shared by the item display sequencer
// and its bench.
package item_seq_pkg;

    typedef logic [2:0] item_code_t;

    localparam item_code_t ITEM_SHOES    = 3'b000;
    localparam item_code_t ITEM_JEWELRY  = 3'b001;
    localparam item_code_t ITEM_ORNAMENT = 3'b010;
    localparam item_code_t ITEM_SUIT     = 3'b100;
    localparam item_code_t ITEM_COAT     = 3'b101;
    localparam item_code_t ITEM_SOCKS    = 3'b111;
    localparam item_code_t ITEM_BLANK    = 3'b011;

    typedef enum logic [1:0] {IDLE, MANUAL, AUTO, FLASH} seq_state_t;

    function automatic logic is_valid_item(input item_code_t code);
        return (code != ITEM_BLANK) && (code != 3'b110);
    endfunction

    // Scroll order; anything outside the valid set restarts at ITEM_SHOES.
    function automatic item_code_t next_item(input item_code_t code);
        case (code)
            ITEM_SHOES:    return ITEM_JEWELRY;
            ITEM_JEWELRY:  return ITEM_ORNAMENT;
            ITEM_ORNAMENT: return ITEM_SUIT;
            ITEM_SUIT:     return ITEM_COAT;
            ITEM_COAT:     return ITEM_SOCKS;
            default:       return ITEM_SHOES;
        endcase
    endfunction

endpackage

// File: rtl/item_display_sequencer_if.sv
// Board-side signals of the item display sequencer. All inputs are plain levels
// (no valid/ready handshake); outputs are registered. state is a debug view.
interface item_display_sequencer_if;
    import item_seq_pkg::*;

    logic       mode_auto;
    item_code_t sel_code;
    logic       step;
    logic       pick;
    item_code_t item_code;
    logic       item_valid;
    logic       flashing;
    logic [7:0] pick_count;
    seq_state_t state;

    modport master (
        output mode_auto, sel_code, step, pick,
        input  item_code, item_valid, flashing, pick_count, state
    );

    modport slave (
        input  mode_auto, sel_code, step, pick,
        output item_code, item_valid, flashing, pick_count, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: tick pulses for one clk each time the count wraps
// from CLK_DIV-1 back to zero.
module tick_prescaler #(
    parameter int CLK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count == CW'(CLK_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/item_display_sequencer.sv
// Item code sequencer: manual pass-through, auto scroll, pick-and-flash.
// Optional ITEM_SEQ_BLINK_EN blinks the locked item against ITEM_BLANK during FLASH.
module item_display_sequencer
    import item_seq_pkg::*;
#(
    parameter int CLK_DIV     = 25_000_000,
    parameter int DWELL_TICKS = 4,
    parameter int FLASH_TICKS = 6
) (
    input logic                     clk,
    input logic                     reset_n,
    item_display_sequencer_if.slave bus
);

    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    logic tick;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    logic step_q, pick_q;
    logic step_edge, pick_edge;

    seq_state_t    state_q, state_d;
    item_code_t    item_code_q, item_code_d;
    item_code_t    locked_q, locked_d;
    logic          item_valid_q, item_valid_d;
    logic          flashing_q, flashing_d;
    logic [7:0]    pick_count_q, pick_count_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [FW-1:0] flash_q, flash_d;
`ifdef ITEM_SEQ_BLINK_EN
    logic          blank_q, blank_d;
`endif

    assign step_edge = bus.step & ~step_q;
    assign pick_edge = bus.pick & ~pick_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            step_q       <= 1'b0;
            pick_q       <= 1'b0;
            item_code_q  <= ITEM_BLANK;
            locked_q     <= ITEM_BLANK;
            item_valid_q <= 1'b0;
            flashing_q   <= 1'b0;
            pick_count_q <= '0;
            dwell_q      <= '0;
            flash_q      <= '0;
`ifdef ITEM_SEQ_BLINK_EN
            blank_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= bus.step;
            pick_q       <= bus.pick;
            item_code_q  <= item_code_d;
            locked_q     <= locked_d;
            item_valid_q <= item_valid_d;
            flashing_q   <= flashing_d;
            pick_count_q <= pick_count_d;
            dwell_q      <= dwell_d;
            flash_q      <= flash_d;
`ifdef ITEM_SEQ_BLINK_EN
            blank_q      <= blank_d;
`endif
        end
    end

    // A pick on a shown valid item outranks both a mode change and a step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = bus.mode_auto ? AUTO : MANUAL;
            MANUAL, AUTO: begin
                if (pick_edge && item_valid_q) state_d = FLASH;
                else                           state_d = bus.mode_auto ? AUTO : MANUAL;
            end
            FLASH: begin
                if (tick && flash_q == FW'(FLASH_TICKS - 1))
                    state_d = bus.mode_auto ? AUTO : MANUAL;
            end
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        item_code_d  = item_code_q;
        locked_d     = locked_q;
        item_valid_d = item_valid_q;
        flashing_d   = (state_d == FLASH);
        pick_count_d = pick_count_q;
        dwell_d      = dwell_q;
        flash_d      = flash_q;
`ifdef ITEM_SEQ_BLINK_EN
        blank_d      = blank_q;
`endif
        case (state_d)
            MANUAL: begin
                item_code_d  = bus.sel_code;
                item_valid_d = is_valid_item(bus.sel_code);
                dwell_d      = '0;
            end
            AUTO: begin
                item_valid_d = 1'b1;
                if (state_q == FLASH) begin
                    item_code_d = locked_q;
                    dwell_d     = '0;
                end else if (state_q != AUTO) begin
                    item_code_d = is_valid_item(item_code_q) ? item_code_q : ITEM_SHOES;
                    dwell_d     = '0;
                end else if (step_edge || (tick && dwell_q == DW'(DWELL_TICKS - 1))) begin
                    item_code_d = next_item(item_code_q);
                    dwell_d     = '0;
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            FLASH: begin
                item_valid_d = 1'b1;
                if (state_q != FLASH) begin
                    locked_d     = item_code_q;
                    pick_count_d = (pick_count_q == 8'hFF) ? 8'hFF : pick_count_q + 8'd1;
                    flash_d      = '0;
`ifdef ITEM_SEQ_BLINK_EN
                    blank_d      = 1'b0;
`endif
                end else if (tick) begin
                    flash_d = flash_q + FW'(1);
`ifdef ITEM_SEQ_BLINK_EN
                    blank_d     = ~blank_q;
                    item_code_d = blank_q ? locked_q : ITEM_BLANK;
`endif
                end
            end
            default: ;
        endcase
    end

    assign bus.item_code  = item_code_q;
    assign bus.item_valid = item_valid_q;
    assign bus.flashing   = flashing_q;
    assign bus.pick_count = pick_count_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_item_display_sequencer.sv
// Directed bench for item_display_sequencer with CLK_DIV=4, DWELL_TICKS=2, FLASH_TICKS=4.
module tb_item_display_sequencer;
  import item_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  item_display_sequencer_if bus();

  item_display_sequencer #(
    .CLK_DIV(4),
    .DWELL_TICKS(2),
    .FLASH_TICKS(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef ITEM_SEQ_BLINK_EN
  localparam item_code_t BL_X = ITEM_BLANK;
`else
  localparam item_code_t BL_X = ITEM_SUIT;
`endif

  typedef struct {
    string      name;
    int         clks;
    logic       mode_auto;
    item_code_t sel_code;
    logic       step;
    logic       pick;
    item_code_t exp_code;
    logic       exp_valid;
    logic       exp_flash;
    logic [7:0] exp_count;
    seq_state_t exp_state;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input int clks, input logic m, input item_code_t sel,
                     input logic s, input logic p, input item_code_t ec, input logic ev,
                     input logic ef, input logic [7:0] en, input seq_state_t es);
    vec_t v;
    v.name = name; v.clks = clks; v.mode_auto = m; v.sel_code = sel; v.step = s; v.pick = p;
    v.exp_code = ec; v.exp_valid = ev; v.exp_flash = ef; v.exp_count = en; v.exp_state = es;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input item_code_t ec, input logic ev,
                               input logic ef, input logic [7:0] en, input seq_state_t es);
    check({name, ".code"},  8'(bus.item_code),  8'(ec));
    check({name, ".valid"}, 8'(bus.item_valid), 8'(ev));
    check({name, ".flash"}, 8'(bus.flashing),   8'(ef));
    check({name, ".count"}, bus.pick_count,     en);
    check({name, ".state"}, 8'(bus.state),      8'(es));
  endtask

  task automatic drive(input logic m, input item_code_t sel, input logic s, input logic p);
    bus.mode_auto = m;
    bus.sel_code  = sel;
    bus.step      = s;
    bus.pick      = p;
  endtask

  initial begin
    // Cycle numbers in the names count posedges since reset release; ticks land on multiples of 4.
    add("auto_entry_c1",   1, 1, 3'b000, 0, 0, ITEM_SHOES,    1, 0, 0, AUTO);
    add("dwell_c7",        6, 1, 3'b000, 0, 0, ITEM_SHOES,    1, 0, 0, AUTO);
    add("adv_c8",          1, 1, 3'b000, 0, 0, ITEM_JEWELRY,  1, 0, 0, AUTO);
    add("adv_c16",         8, 1, 3'b000, 0, 0, ITEM_ORNAMENT, 1, 0, 0, AUTO);
    add("adv_c24",         8, 1, 3'b000, 0, 0, ITEM_SUIT,     1, 0, 0, AUTO);
    add("adv_c32",         8, 1, 3'b000, 0, 0, ITEM_COAT,     1, 0, 0, AUTO);
    add("adv_c40",         8, 1, 3'b000, 0, 0, ITEM_SOCKS,    1, 0, 0, AUTO);
    add("wrap_c48",        8, 1, 3'b000, 0, 0, ITEM_SHOES,    1, 0, 0, AUTO);
    add("adv_c56",         8, 1, 3'b000, 0, 0, ITEM_JEWELRY,  1, 0, 0, AUTO);
    add("pre_step_c62",    6, 1, 3'b000, 0, 0, ITEM_JEWELRY,  1, 0, 0, AUTO);
    add("step_c63",        1, 1, 3'b000, 1, 0, ITEM_ORNAMENT, 1, 0, 0, AUTO);
    add("no_dbl_c64",      1, 1, 3'b000, 1, 0, ITEM_ORNAMENT, 1, 0, 0, AUTO);
    add("held_c67",        3, 1, 3'b000, 1, 0, ITEM_ORNAMENT, 1, 0, 0, AUTO);
    add("restart_c68",     1, 1, 3'b000, 1, 0, ITEM_SUIT,     1, 0, 0, AUTO);
    add("held_c83",       15, 1, 3'b000, 1, 0, ITEM_COAT,     1, 0, 0, AUTO);
    add("release_c84",     1, 1, 3'b000, 0, 0, ITEM_SOCKS,    1, 0, 0, AUTO);
    add("man_110_c85",     1, 0, 3'b110, 0, 0, 3'b110,        0, 0, 0, MANUAL);
    add("pick_ign_c86",    1, 0, 3'b110, 0, 1, 3'b110,        0, 0, 0, MANUAL);
    add("man_101_c87",     1, 0, 3'b101, 0, 0, ITEM_COAT,     1, 0, 0, MANUAL);
    add("man_100_c88",     1, 0, 3'b100, 0, 0, ITEM_SUIT,     1, 0, 0, MANUAL);
    add("to_auto_c89",     1, 1, 3'b100, 0, 0, ITEM_SUIT,     1, 0, 0, AUTO);
    add("pick_step_c90",   1, 1, 3'b100, 1, 1, ITEM_SUIT,     1, 1, 1, FLASH);
    add("flash_t1_c92",    2, 1, 3'b100, 1, 1, BL_X,          1, 1, 1, FLASH);
    add("flash_t2_c96",    4, 1, 3'b100, 1, 1, ITEM_SUIT,     1, 1, 1, FLASH);
    add("flash_t3_c100",   4, 1, 3'b100, 1, 1, BL_X,          1, 1, 1, FLASH);
    add("flash_end_c103",  3, 1, 3'b100, 1, 1, BL_X,          1, 1, 1, FLASH);
    add("resume_c104",     1, 1, 3'b100, 1, 1, ITEM_SUIT,     1, 0, 1, AUTO);
    add("dwell_c111",      7, 1, 3'b100, 0, 0, ITEM_SUIT,     1, 0, 1, AUTO);
    add("adv_c112",        1, 1, 3'b100, 0, 0, ITEM_COAT,     1, 0, 1, AUTO);

    // Reset held five clocks with mode_auto high.
    drive(1, 3'b000, 0, 0);
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", ITEM_BLANK, 0, 0, 0, IDLE);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].mode_auto, vq[i].sel_code, vq[i].step, vq[i].pick);
      repeat (vq[i].clks) @(posedge clk);
      @(negedge clk);
      check_outputs(vq[i].name, vq[i].exp_code, vq[i].exp_valid, vq[i].exp_flash,
                    vq[i].exp_count, vq[i].exp_state);
    end

    // Picks 2..255: each must enter FLASH and the flash must end within budget.
    for (int k = 2; k <= 255; k++) begin
      drive(1, 3'b000, 0, 1);
      @(posedge clk);
      @(negedge clk);
      bus.pick = 1'b0;
      if (k == 254 || k == 255) begin
        check("sat_flash", 8'(bus.flashing), 8'd1);
        check("sat_count", bus.pick_count, 8'(k));
      end
      for (int w = 0; w < 40 && bus.flashing; w++) @(negedge clk);
      check("flash_timeout", 8'(bus.flashing), 8'd0);
    end

    // Pick 256 saturates, then reset lands mid-flash.
    bus.pick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pick = 1'b0;
    check_outputs("sat_256", bus.item_code, 1, 1, 8'd255, FLASH);
    check("sat_256.valid_code", 8'(is_valid_item(bus.item_code)), 8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs("reset_mid_flash", ITEM_BLANK, 0, 0, 0, IDLE);

    // Release into manual mode: IDLE hands over to MANUAL with the switch code.
    drive(0, 3'b111, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("manual_entry", ITEM_SOCKS, 1, 0, 0, MANUAL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
